// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module : mux_arb_pkg
// Brief  : Shared types, constants and round-robin search for the 4:1 mux arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First requester found searching ptr, ptr+1, ... with natural 2-bit wrap.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req,
                                           input logic [1:0]      ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_4_1.sv
// ============================================================================
// Module : mux_4_1
// Brief  : 4:1 datapath mux of DW-wide slices, output forced to zero when disabled.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_4_1 #(
    parameter int DW = 1
) (
    input  logic [1:0]      sel_i,
    input  logic [4*DW-1:0] din_i,
    input  logic            en_i,
    output logic [DW-1:0]   dout_o
);

    always_comb begin
        dout_o = '0;
        if (en_i) begin
            case (sel_i)
                2'd0:    dout_o = din_i[0*DW +: DW];
                2'd1:    dout_o = din_i[1*DW +: DW];
                2'd2:    dout_o = din_i[2*DW +: DW];
                default: dout_o = din_i[3*DW +: DW];
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_4_1_rr_arbiter.sv
// ============================================================================
// Module : mux_4_1_rr_arbiter
// Brief  : Round-robin arbiter with per-grant burst limit driving a shared 4:1 mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW        = 1,
    parameter int MAX_BURST = 4,
    parameter int CW        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] din,
    input  logic            out_ready,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            out_valid,
    output logic [DW-1:0]   dout,
    output logic            busy
);

    localparam logic [CW-1:0] c_LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic [3:0]    gnt_q,   gnt_d;
    logic [1:0]    sel_q,   sel_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          w_out_valid;
    logic          w_xfer;
    logic          w_release;
    logic [1:0]    w_pick;

    assign w_out_valid = (state_q == GRANT) && req[sel_q];
    assign w_xfer      = w_out_valid && out_ready;
    assign w_pick      = rr_pick(req, ptr_q);
    // Release on dropped request, or on the final beat even if still requesting.
    assign w_release   = !req[sel_q] || (w_xfer && (cnt_q == c_LAST_BEAT));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = w_pick;
                    gnt_d   = 4'b0001 << w_pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            default: begin
                if (w_release) begin
                    gnt_d   = '0;
                    ptr_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (w_xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    mux_4_1 #(
        .DW (DW)
    ) u_mux (
        .sel_i  (sel_q),
        .din_i  (din),
        .en_i   (w_out_valid),
        .dout_o (dout)
    );

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = w_out_valid;
    assign busy      = (state_q == GRANT);

endmodule

`default_nettype wire

// File: tb/tb_mux_4_1_rr_arbiter.sv
// ============================================================================
// Module : tb_mux_4_1_rr_arbiter
// Brief  : Two arbiter instances (burst 4 / burst 1) checked against a grant-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_4_1_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] din_a = '0;
    logic [3:0]  din_b = '0;
    logic        out_ready = 1'b0;

    logic [3:0]  gnt_a, gnt_b;
    logic [1:0]  sel_a, sel_b;
    logic        ov_a, ov_b, busy_a, busy_b;
    logic [3:0]  dout_a;
    logic [0:0]  dout_b;

    int checks = 0;
    int errors = 0;

    // model state per instance: 0 = DW4/burst4, 1 = DW1/burst1
    bit m_granted [2];
    int m_owner   [2];
    int m_ptr     [2];
    int m_beats   [2];
    int m_sel     [2];
    int m_limit   [2] = '{4, 1};

    always #5 clk = ~clk;

    mux_4_1_rr_arbiter #(.DW(4), .MAX_BURST(4), .CW(3)) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .din(din_a), .out_ready(out_ready),
        .gnt(gnt_a), .sel(sel_a), .out_valid(ov_a), .dout(dout_a), .busy(busy_a)
    );

    mux_4_1_rr_arbiter #(.DW(1), .MAX_BURST(1), .CW(1)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .din(din_b), .out_ready(out_ready),
        .gnt(gnt_b), .sel(sel_b), .out_valid(ov_b), .dout(dout_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_granted[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_beats[d] = 0; m_sel[d] = 0;
        end
    endtask

    task automatic model_step(input int d);
        if (!m_granted[d]) begin
            if (req != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (!m_granted[d] && req[(m_ptr[d] + i) % 4]) begin
                        m_granted[d] = 1;
                        m_owner[d]   = (m_ptr[d] + i) % 4;
                    end
                end
                m_sel[d]   = m_owner[d];
                m_beats[d] = 0;
            end
        end else if (!req[m_owner[d]]) begin
            m_granted[d] = 0;
            m_ptr[d]     = (m_owner[d] + 1) % 4;
        end else if (out_ready) begin
            m_beats[d]++;
            if (m_beats[d] == m_limit[d]) begin
                m_granted[d] = 0;
                m_ptr[d]     = (m_owner[d] + 1) % 4;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] e_gnt;
        logic       e_ov;
        logic [3:0] e_dout;
        for (int d = 0; d < 2; d++) begin
            e_gnt  = m_granted[d] ? (4'b0001 << m_owner[d]) : 4'b0;
            e_ov   = m_granted[d] && req[m_owner[d]];
            e_dout = '0;
            if (e_ov) e_dout = (d == 0) ? 4'((din_a >> (4 * m_owner[d])) & 16'hF)
                                        : {3'b0, din_b[m_owner[d]]};
            chk(d == 0 ? "a.gnt"  : "b.gnt",  16'(d == 0 ? gnt_a : gnt_b), 16'(e_gnt));
            chk(d == 0 ? "a.sel"  : "b.sel",  16'(d == 0 ? sel_a : sel_b), 16'(m_sel[d]));
            chk(d == 0 ? "a.busy" : "b.busy", 16'(d == 0 ? busy_a : busy_b), 16'(m_granted[d]));
            chk(d == 0 ? "a.out_valid" : "b.out_valid", 16'(d == 0 ? ov_a : ov_b), 16'(e_ov));
            chk(d == 0 ? "a.dout" : "b.dout", 16'(d == 0 ? dout_a : {3'b0, dout_b}), 16'(e_dout));
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic [15:0] da, input logic [3:0] db,
                         input logic rd);
        @(negedge clk);
        req = r; din_a = da; din_b = db; out_ready = rd;
        #1;
        check_model();
        @(posedge clk);
        if (!rst) begin
            model_step(0);
            model_step(1);
        end
    endtask

    // Async reset asserted between edges; outputs must collapse before any clock edge.
    task automatic reset_pulse();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst.gnt",       16'(gnt_a),  16'h0);
        chk("rst.busy",      16'(busy_a), 16'h0);
        chk("rst.out_valid", 16'(ov_a),   16'h0);
        chk("rst.sel",       16'(sel_a),  16'h0);
        chk("rst.dout",      16'(dout_a), 16'h0);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [47:0] hist;

    initial begin
        model_reset();
        reset_pulse();

        // single requester, burst of 4, bubble, regrant
        hist = '0;
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0001, 16'h0001, 4'b0001, 1'b1);
            hist = {hist[46:0], busy_a};
        end
        chk("single.busy_pattern", 16'(hist[6:0]), 16'b0111101);

        // strict round-robin with burst 1
        reset_pulse();
        hist = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1111, 16'h4321, 4'b1010, 1'b1);
            hist = {hist[43:0], gnt_b};
        end
        chk("fair.lo", hist[15:0],  16'h0801);
        chk("fair.hi", hist[39:16], 16'h0204);
        checks++;
        if (hist[39:0] !== 40'h0102040801) begin
            errors++;
            $display("FAIL fair.order actual=%h required=%h", hist[39:0], 40'h0102040801);
        end

        // backpressure: 5 stalled cycles, beat stays on slice 1
        reset_pulse();
        for (int i = 0; i < 6; i++) cycle(4'b0010, 16'h00A0, 4'b0010, 1'b0);
        #2;
        chk("bp.out_valid", 16'(ov_a),   16'h1);
        chk("bp.dout",      16'(dout_a), 16'hA);
        for (int i = 0; i < 6; i++) cycle(4'b0010, 16'h00A0, 4'b0010, 1'b1);

        // early release of requester 3, requester 1 wins next search from ptr 0
        reset_pulse();
        hist = '0;
        cycle(4'b1000, 16'h9000, 4'b1000, 1'b1); hist = {hist[43:0], gnt_a};
        cycle(4'b1010, 16'h9050, 4'b1010, 1'b1); hist = {hist[43:0], gnt_a};
        cycle(4'b1010, 16'h9050, 4'b1010, 1'b1); hist = {hist[43:0], gnt_a};
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0010, 16'h0050, 4'b0010, 1'b1);
            hist = {hist[43:0], gnt_a};
        end
        chk("early.seq", 16'(hist[23:0] >> 8), 16'h0888);
        chk("early.tail", 16'(hist[7:0]), 16'h02);

        // burst boundary with sustained requests on 0 and 2
        reset_pulse();
        hist = '0;
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0101, 16'h0706, 4'b0101, 1'b1);
            hist = {hist[43:0], gnt_a};
        end
        checks++;
        if (hist !== 48'h011110444401) begin
            errors++;
            $display("FAIL burst.order actual=%h required=%h", hist, 48'h011110444401);
        end

        // reset mid-grant, then requester 2 is granted one cycle after release
        reset_pulse();
        cycle(4'b0100, 16'h0B00, 4'b0100, 1'b0);
        cycle(4'b0100, 16'h0B00, 4'b0100, 1'b0);
        chk("midrst.pre_busy", 16'(busy_a), 16'h1);
        reset_pulse();
        cycle(4'b0100, 16'h0B00, 4'b0100, 1'b1);
        cycle(4'b0100, 16'h0B00, 4'b0100, 1'b1);
        chk("midrst.regrant", 16'(gnt_a), 16'h4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
            end else begin
                cycle(4'($urandom), 16'($urandom), 4'($urandom),
                      $urandom_range(0, 3) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 4:1 mux. Four requesters present data slices. The block grants one requester at a time, drives the mux select, and forwards the selected slice to a single consumer over a valid/ready handshake. A burst limit per grant prevents any requester from starving the others.

Parameters:
DW, 1, data width per requester slice
MAX_BURST, 4, max beats transferred per grant before forced release (>=1)
CW, 3, burst counter width, must hold MAX_BURST

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  per-requester request, level, held while data pending
din  input  4*DW  requester data; slice k = din[k*DW +: DW]
out_ready  input  1  consumer accepts beat this cycle
gnt  output  4  one-hot grant, registered
sel  output  2  mux select = index of granted requester, registered
out_valid  output  1  beat presented to consumer
dout  output  DW  selected data slice
busy  output  1  high while in GRANT state

Behaviour:
- One clock domain. Reset is asynchronous and active-high on rst. All state is cleared on assertion. No output glitch on deassertion; first arbitration occurs on the first clk edge after rst falls.
- Reset values:
  - state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, busy=0
  - out_valid=0, dout=0
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, pick the first k with req[k]=1, searching k = ptr, ptr+1, ... mod 4.
  - Next edge: sel<=k, gnt<=1<<k, cnt<=0, state<=GRANT.
  - Arbitration latency is exactly 1 cycle from req visible to gnt high.
- State GRANT:
  - out_valid = req[sel] (combinational).
  - dout = din slice[sel] when out_valid, else 0.
  - A transfer occurs on an edge where out_valid && out_ready. On a transfer, cnt<=cnt+1.
- Release from GRANT to IDLE:
  - Condition (a): req[sel]=0.
  - Condition (b): a transfer with cnt==MAX_BURST-1.
  - On release: gnt<=0, ptr<=sel+1 (wraps 3 to 0), cnt<=0. sel holds its last value.
  - Release creates exactly one bubble cycle (IDLE) between grants.
- Simultaneous events:
  - Burst-limit transfer while the same requester still requests: release anyway. That requester ranks last in the next search.
  - Request from a non-granted requester during GRANT: ignored until IDLE.
  - req[sel] drops in the same cycle out_ready rises: no transfer, release.
- out_ready low: the beat stalls and cnt is unchanged. There is no timeout.
- Reset mid-burst: the grant is dropped immediately (async). The in-flight beat is lost. ptr returns to 0.
- Requesters must not change their din slice while their request is held and not yet accepted. Violating this is not a block error; dout simply follows din.
- Width rules:
  - sel and ptr are 2 bits with natural wrap.
  - cnt compare uses CW bits.
  - MAX_BURST=1 gives strict one-beat round-robin.

Decomposition:
- Shared package mux_arb_pkg:
  - state enum {IDLE, GRANT}
  - localparam NREQ=4
  - function rr_pick(req, ptr) returning a 2-bit index
- One natural sub-module: mux_4_1 (the existing datapath mux), instantiated for dout. It uses sel and a DW-wide slice per port, with its output gated by out_valid.
- The arbitration search stays inline via rr_pick. There is no separate priority-encoder module.

Test Plan:
- Reset check: assert rst mid-GRANT with req=4'b0100 -> gnt, out_valid and busy go 0 immediately; after release, the first grant goes to requester 2 (ptr=0, only req[2] set) one cycle later.
- Single requester: req=4'b0001, din slice0=1, out_ready=1, MAX_BURST=4 -> gnt=0001, sel=00; 4 beats of dout=1; then one IDLE cycle; then a regrant to requester 0.
- Round-robin fairness: req=4'b1111, out_ready=1, MAX_BURST=1 -> grant order 0,1,2,3,0; one beat each; a bubble between each grant.
- Backpressure: req=4'b0010, out_ready low for 5 cycles then high -> out_valid held high for 5 cycles, cnt stays 0, dout stable = slice1; transfers resume when out_ready rises.
- Early release: requester 3 granted, drops req after 2 beats, req[1] waiting -> release with cnt=2; next grant goes to requester 1 (search from ptr=0 wraps to 1); ptr after release = 0.
- Burst boundary with sustained request: req=4'b0101, MAX_BURST=4 -> requester 0 gets 4 beats, then requester 2 gets 4 beats, then requester 0 again.
